// File: rtl/answer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : answer_pkg
// Description : Shared defaults, FSM state type and gene extraction helper
//               for the answer streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package answer_pkg;

    localparam int DEF_POP_SIZE  = 10;
    localparam int DEF_NUM_GENES = 30;
    localparam int DEF_GENE_W    = 5;
    localparam int DEF_OUT_W     = 8;
    localparam int DEF_IDX_W     = 4;

    // Upper bounds for the helper's argument and result vectors
    localparam int GS_MAX_W = 4096;
    localparam int GS_SYM_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    // Gene g of individual idx, zero-extended; individual 0 and gene 0 are
    // the most significant slices of pop.
    function automatic logic [GS_SYM_W-1:0] gene_slice(
        input logic [GS_MAX_W-1:0] pop,
        input int unsigned         idx,
        input int unsigned         g,
        input int unsigned         pop_size,
        input int unsigned         num_genes,
        input int unsigned         gene_w
    );
        int unsigned         lsb;
        logic [GS_MAX_W-1:0] shifted;
        logic [GS_SYM_W-1:0] mask;
        lsb     = ((pop_size - idx - 1) * num_genes + (num_genes - 1 - g)) * gene_w;
        shifted = pop >> lsb;
        mask    = (GS_SYM_W'(1) << gene_w) - GS_SYM_W'(1);
        return shifted[GS_SYM_W-1:0] & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/answer_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : answer_streamer_if
// Description : Valid/ready symbol stream between the streamer and its sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface answer_streamer_if
    import answer_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input  out_ready);
    modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/answer_capture.sv
`default_nettype none
// ============================================================================
// Module      : answer_capture
// Description : Selects one individual from the population and holds it in a
//               shadow register plus a zero-extended parallel answer word.
// Revision    : 1.0 - initial release
// ============================================================================
module answer_capture
    import answer_pkg::*;
#(
    parameter int POP_SIZE  = DEF_POP_SIZE,
    parameter int NUM_GENES = DEF_NUM_GENES,
    parameter int GENE_W    = DEF_GENE_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  wire logic                                 clk,
    input  wire logic                                 rst,
    input  wire logic [POP_SIZE*NUM_GENES*GENE_W-1:0] sel_population,
    input  wire logic [IDX_W-1:0]                     sel_idx,
    input  wire logic                                 capture,
    output logic      [NUM_GENES*GENE_W-1:0]          sel_ind,
    output logic      [NUM_GENES*GENE_W-1:0]          shadow,
    output logic      [NUM_GENES*OUT_W-1:0]           answer
);

    localparam int c_IND_W = NUM_GENES * GENE_W;
    localparam int c_ANS_W = NUM_GENES * OUT_W;

    logic [c_IND_W-1:0] w_sel_ind;
    logic [c_IND_W-1:0] shadow_d, shadow_q;
    logic [c_ANS_W-1:0] answer_d, answer_q;

    always_comb begin
        w_sel_ind = '0;
        for (int i = 0; i < POP_SIZE; i++) begin
            if (int'(sel_idx) == i) begin
                w_sel_ind = sel_population[(POP_SIZE-1-i)*c_IND_W +: c_IND_W];
            end
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        answer_d = answer_q;
        if (capture) begin
            shadow_d = w_sel_ind;
            for (int g = 0; g < NUM_GENES; g++) begin
                answer_d[(NUM_GENES-1-g)*OUT_W +: OUT_W] =
                    OUT_W'(w_sel_ind[(NUM_GENES-1-g)*GENE_W +: GENE_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            answer_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            answer_q <= answer_d;
        end
    end

    assign sel_ind = w_sel_ind;
    assign shadow  = shadow_q;
    assign answer  = answer_q;

endmodule
`default_nettype wire

// File: rtl/answer_streamer.sv
`default_nettype none
// ============================================================================
// Module      : answer_streamer
// Description : Captures a selected individual and streams it as an optional
//               header + genes + XOR checksum frame over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module answer_streamer
    import answer_pkg::*;
#(
    parameter int POP_SIZE  = DEF_POP_SIZE,
    parameter int NUM_GENES = DEF_NUM_GENES,
    parameter int GENE_W    = DEF_GENE_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  wire logic                                 clk,
    input  wire logic                                 rst,
    input  wire logic [POP_SIZE*NUM_GENES*GENE_W-1:0] sel_population,
    input  wire logic                                 start,
    input  wire logic [IDX_W-1:0]                     sel_idx,
    input  wire logic                                 frame_en,
    output logic      [NUM_GENES*OUT_W-1:0]           answer,
    answer_streamer_if.master                         stream,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      err
);

    localparam int c_IND_W = NUM_GENES * GENE_W;
    localparam int c_CNT_W = (NUM_GENES > 1) ? $clog2(NUM_GENES) : 1;
    localparam logic [OUT_W-1:0]   c_HDR      = OUT_W'(NUM_GENES);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(NUM_GENES - 1);

    state_e             state_d, state_q;
    logic [c_CNT_W-1:0] gene_cnt_d, gene_cnt_q;
    logic [OUT_W-1:0]   csum_d, csum_q;
    logic [OUT_W-1:0]   out_data_d, out_data_q;
    logic               out_valid_d, out_valid_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;
    logic               err_d, err_q;
    logic               frame_d, frame_q;

    logic               w_idx_ok;
    logic               w_accept;
    logic               w_hs;
    logic [c_IND_W-1:0] w_sel_ind;
    logic [c_IND_W-1:0] w_shadow;
    logic [OUT_W-1:0]   w_first_gene;
    logic [OUT_W-1:0]   w_next_gene;
    int unsigned        w_next_idx;

    assign w_idx_ok = (int'(sel_idx) < POP_SIZE);
    assign w_accept = (state_q == ST_IDLE) && start && w_idx_ok;
    assign w_hs     = out_valid_q && stream.out_ready;

    answer_capture #(
        .POP_SIZE  (POP_SIZE),
        .NUM_GENES (NUM_GENES),
        .GENE_W    (GENE_W),
        .OUT_W     (OUT_W),
        .IDX_W     (IDX_W)
    ) u_capture (
        .clk            (clk),
        .rst            (rst),
        .sel_population (sel_population),
        .sel_idx        (sel_idx),
        .capture        (w_accept),
        .sel_ind        (w_sel_ind),
        .shadow         (w_shadow),
        .answer         (answer)
    );

    // An unframed frame starts before the shadow is loaded, so its first gene
    // comes straight from the selection mux.
    assign w_first_gene = OUT_W'(gene_slice(GS_MAX_W'(w_sel_ind), 0, 0, 1,
                                            NUM_GENES, GENE_W));
    assign w_next_idx   = (state_q == ST_HDR) ? 32'd0 : (32'(gene_cnt_q) + 32'd1);
    assign w_next_gene  = OUT_W'(gene_slice(GS_MAX_W'(w_shadow), 0, w_next_idx, 1,
                                            NUM_GENES, GENE_W));

    always_comb begin
        state_d     = state_q;
        gene_cnt_d  = gene_cnt_q;
        csum_d      = csum_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        frame_d     = frame_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !w_idx_ok) begin
                    err_d = 1'b1;
                end else if (w_accept) begin
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    gene_cnt_d  = '0;
                    frame_d     = frame_en;
                    if (frame_en) begin
                        state_d    = ST_HDR;
                        out_data_d = c_HDR;
                        csum_d     = c_HDR;
                    end else begin
                        state_d    = ST_BODY;
                        out_data_d = w_first_gene;
                        csum_d     = w_first_gene;
                    end
                end
            end
            ST_HDR: begin
                if (w_hs) begin
                    state_d    = ST_BODY;
                    gene_cnt_d = '0;
                    out_data_d = w_next_gene;
                    csum_d     = csum_q ^ w_next_gene;
                end
            end
            ST_BODY: begin
                if (w_hs) begin
                    if (gene_cnt_q == c_LAST_CNT) begin
                        if (frame_q) begin
                            state_d    = ST_CSUM;
                            out_data_d = csum_q;
                        end else begin
                            state_d     = ST_IDLE;
                            out_data_d  = '0;
                            out_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                        end
                    end else begin
                        gene_cnt_d = gene_cnt_q + c_CNT_W'(1);
                        out_data_d = w_next_gene;
                        csum_d     = csum_q ^ w_next_gene;
                    end
                end
            end
            ST_CSUM: begin
                if (w_hs) begin
                    state_d     = ST_IDLE;
                    out_data_d  = '0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gene_cnt_q  <= '0;
            csum_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gene_cnt_q  <= gene_cnt_d;
            csum_q      <= csum_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
        end
    end

    assign stream.out_data  = out_data_q;
    assign stream.out_valid = out_valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule
`default_nettype wire

// File: doc/answer_streamer.md
# answer_streamer

Parametrised successor to the fixed-width answer packager. Captures one selected individual (tour) out of the flat population vector and delivers it both as a zero-extended parallel word and as a byte-stream frame over a valid/ready handshake. Sits between the GA selection stage and the host/UART transmit path. Population size, gene count, gene width and output symbol width are all parameters, and the source individual is chosen at run time.

## Interface
- `POP_SIZE`, 10, individuals in `sel_population`
- `NUM_GENES`, 30, genes (cities) per individual
- `GENE_W`, 5, bits per gene; must satisfy `GENE_W <= OUT_W`
- `OUT_W`, 8, bits per output symbol
- `IDX_W`, 4, width of `sel_idx`; must satisfy `2**IDX_W >= POP_SIZE`
- `clk  in  1  system clock; all logic on rising edge`
- `rst  in  1  synchronous, active-high reset`
- `sel_population  in  POP_SIZE*NUM_GENES*GENE_W  flat population; individual 0 in the most significant slice`
- `start  in  1  single-cycle request to capture and send`
- `sel_idx  in  IDX_W  individual to capture, sampled with `start``
- `frame_en  in  1  sampled with `start`; 1 = header + genes + checksum, 0 = genes only`
- `answer  out  NUM_GENES*OUT_W  registered parallel answer; gene 0 in the most significant symbol`
- `out_data  out  OUT_W  stream symbol`
- `out_valid  out  1  `out_data` valid`
- `out_ready  in  1  downstream accepts the symbol`
- `busy  out  1  frame in progress`
- `done  out  1  one-cycle pulse after the last symbol is accepted`
- `err  out  1  one-cycle pulse when `start` is rejected for an out-of-range `sel_idx``

## Operation
- Individual i occupies bits [(POP_SIZE-i)*IND_W-1 : (POP_SIZE-i-1)*IND_W], where IND_W = NUM_GENES*GENE_W. Within an individual, gene 0 is the most significant GENE_W bits.
- Each symbol is a gene zero-extended on the left to OUT_W bits.
- FSM states and transitions:
  - IDLE → HDR when `start` is accepted with frame_en=1.
  - IDLE → BODY when `start` is accepted with frame_en=0.
  - HDR → BODY.
  - BODY → CSUM after gene NUM_GENES-1 if framed; BODY → IDLE after gene NUM_GENES-1 if unframed.
  - CSUM → IDLE.
  - Each transition happens only on a handshake (out_valid && out_ready).
- An accepted `start` (IDLE, sel_idx < POP_SIZE) latches the selected individual into a shadow register and updates `answer`. `sel_population` may change freely afterwards.
- Header symbol = NUM_GENES mod 2**OUT_W.
- Checksum symbol = XOR of every symbol sent in the frame, header included.
- Gene counter runs from 0 to NUM_GENES-1 and is cleared on entry to BODY.
- `start` while busy is ignored: no capture, no err, `answer` unchanged.
- `start` with sel_idx ≥ POP_SIZE in IDLE: err pulse next cycle, no capture, state remains IDLE.
- `answer` holds its value until the next accepted `start`.

## Timing
- Reset values:
  - `answer` = 0, `out_data` = 0
  - `out_valid` = 0, `busy` = 0, `done` = 0, `err` = 0
  - state = IDLE, shadow register = 0
- `start` is sampled in cycle 0. In cycle 1, `answer`, `busy` and `out_valid` are high/updated and `out_data` shows the first symbol.
- Once `out_valid` is high, `out_data` is stable until the handshake. `out_valid` never drops without a handshake, except on reset.
- One symbol per cycle at full throughput. A framed frame takes NUM_GENES+2 cycles with `out_ready` held high; an unframed frame takes NUM_GENES cycles.
- The cycle after the final handshake: `done`=1, `busy`=0, `out_valid`=0.
- A `start` in the same cycle as `done` is accepted, so back-to-back frames have one idle cycle between them.
- Reset mid-frame aborts the frame immediately with no `done`. All outputs return to their reset values on the next edge.

## Structure
- A shared package `answer_pkg` holds:
  - the default parameter values
  - an FSM state enum (IDLE, HDR, BODY, CSUM)
  - a function `gene_slice(pop, idx, g)` returning the zero-extended symbol
- One sub-module, `answer_capture`: a combinational mux selecting the individual plus the shadow/`answer` registers.
- The FSM, counter and checksum live in the top level.

## Test plan
- Defaults; individual 0 genes = 0..29; start with sel_idx=0, frame_en=1, out_ready=1 → symbols 0x1E, 0x00..0x1D, then checksum 0x1F; done in cycle 33; answer[239:232]=0x00, answer[7:0]=0x1D.
- Individual 9 all genes 5'h1F; sel_idx=9; out_ready toggling 1010… → 30 data symbols 0x1F, checksum 0x1E; out_data stable during every stall; done only after the last handshake.
- frame_en=0, sel_idx=3 → exactly 30 symbols, no header, no checksum; done 30 cycles after the first valid with out_ready=1.
- sel_idx=10 → err pulse in cycle 1; out_valid, busy and answer unchanged.
- Mid-frame: start pulsed again with different sel_idx and population changed → ignored; the stream completes with the original individual.
- rst asserted at symbol 12 → next cycle out_valid=0, busy=0, answer=0, no done; a fresh start then produces a complete frame.
